// File: rtl/dma_packetizer.sv
// Packs 32-bit accelerator words into 128-bit beats and emits each message as a
// length header followed by its payload beats, force-splitting overlong messages.
module dma_packetizer #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LEN_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] dout,
  output logic         valid,
  input  logic         ready,
  output logic [31:0]  pkt_cnt,
  output logic         split_err
);

  localparam int DDEPTH = 1 << DEPTH_LOG2;
  localparam int LW     = DEPTH_LOG2 + 1;
  localparam int LPW    = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
  localparam int LCW    = $clog2(LEN_DEPTH + 1);
  localparam logic [LW-1:0] MAXB = LW'(DDEPTH - 1);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  logic [1:0]    wcnt;
  logic [95:0]   part;
  logic [127:0]  beat_next;
  logic [LW-1:0] bcnt, bcnt_inc, len_in;
  logic          accept, dpush, hit_max, lpush;

  logic [127:0]          dmem [DDEPTH];
  logic [DEPTH_LOG2-1:0] dwr, drd;
  logic [LW-1:0]         dcount;
  logic                  dpop, dfull;

  logic [LW-1:0]  lmem [LEN_DEPTH];
  logic [LPW-1:0] lwr, lrd;
  logic [LCW-1:0] lcount;
  logic [LW-1:0]  lhead;
  logic           lpop, lfull, lavail;

  state_t        state;
  logic [LW-1:0] rem;
  logic          fire, last_beat;

  function automatic logic [LPW-1:0] lnext(input logic [LPW-1:0] p);
    return (p == LPW'(LEN_DEPTH - 1)) ? '0 : p + LPW'(1);
  endfunction

  // ---------------- input packing ----------------
  always_comb begin
    beat_next = {32'd0, part};
    for (int unsigned i = 0; i < 4; i++)
      if (wcnt == 2'(i)) beat_next[i*32 +: 32] = in_data;
  end

  assign in_ready = !reset && !dfull && !lfull;
  assign accept   = in_valid && in_ready;
  assign dpush    = accept && (wcnt == 2'd3 || in_last);
  assign bcnt_inc = bcnt + LW'(1);
  assign hit_max  = (bcnt_inc == MAXB);
  assign lpush    = dpush && (in_last || hit_max);
  assign len_in   = bcnt_inc + LW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt      <= '0;
      part      <= '0;
      bcnt      <= '0;
      split_err <= 1'b0;
    end else if (accept) begin
      if (dpush) begin
        wcnt <= '0;
        part <= '0;
        bcnt <= lpush ? '0 : bcnt_inc;
        if (hit_max && !in_last) split_err <= 1'b1;
      end else begin
        wcnt <= wcnt + 2'd1;
        part <= beat_next[95:0];
      end
    end
  end

  // ---------------- data FIFO ----------------
  assign dfull = (dcount == LW'(DDEPTH));

  always_ff @(posedge clk) begin
    if (dpush) dmem[dwr] <= beat_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwr    <= '0;
      drd    <= '0;
      dcount <= '0;
    end else begin
      if (dpush) dwr <= dwr + 1'b1;
      if (dpop)  drd <= drd + 1'b1;
      dcount <= dcount + LW'(dpush) - LW'(dpop);
    end
  end

  // ---------------- length FIFO ----------------
  // An entry written on the same edge it is popped bypasses storage via len_in.
  assign lfull  = (lcount == LCW'(LEN_DEPTH));
  assign lavail = (lcount != '0) || lpush;
  assign lhead  = (lcount != '0) ? lmem[lrd] : len_in;

  always_ff @(posedge clk) begin
    if (lpush) lmem[lwr] <= len_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lwr    <= '0;
      lrd    <= '0;
      lcount <= '0;
    end else begin
      if (lpush) lwr <= lnext(lwr);
      if (lpop)  lrd <= lnext(lrd);
      lcount <= lcount + LCW'(lpush) - LCW'(lpop);
    end
  end

  // ---------------- output FSM ----------------
  // dout is a register loaded from the FIFO heads; entries leave their FIFO
  // when loaded, and rem counts payload beats still to be loaded.
  assign fire      = valid && ready;
  assign last_beat = (state == PAYLOAD) && fire && (rem == '0);
  assign lpop      = ((state == IDLE) || last_beat) && lavail;
  assign dpop      = fire && ((state == HEADER) || (state == PAYLOAD && rem != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      valid   <= 1'b0;
      dout    <= '0;
      rem     <= '0;
      pkt_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (lavail) begin
            state <= HEADER;
            valid <= 1'b1;
            dout  <= 128'(lhead);
            rem   <= lhead - LW'(1);
          end
        end
        HEADER: begin
          if (fire) begin
            state <= PAYLOAD;
            dout  <= dmem[drd];
            rem   <= rem - LW'(1);
          end
        end
        PAYLOAD: begin
          if (fire) begin
            if (rem != '0) begin
              dout <= dmem[drd];
              rem  <= rem - LW'(1);
            end else begin
              pkt_cnt <= pkt_cnt + 32'd1;
              if (lavail) begin
                state <= HEADER;
                dout  <= 128'(lhead);
                rem   <= lhead - LW'(1);
              end else begin
                state <= IDLE;
                valid <= 1'b0;
                dout  <= '0;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
